ex_stage: RTL
=============

// Module: ex_stage
// PURPOSE
//  Execute stage of the 5-stage scalar pipeline; sits between ID and the combinational mem_stage.
//  Owns the ID->EX pipeline register and evaluates the ALU.
//  Runs a multi-cycle radix-2 divider for DIV/MOD ops.
//  Issues the data-SRAM request so read data returns during MEM, and drives the 71-bit MEM bundle.
// PARAMETERS
//  XLEN      32   datapath width; only 32 is supported
//  DIV_ITER  32   divider iterations; must equal XLEN
// PORTS
//  clk               in   1    rising-edge clock
//  resetn            in   1    asynchronous, active-low reset
//  ID_signal_valid   in   1    ID holds a valid instruction
//  ID_signal         in   151  {pc[32], alu_op[12], div_en, div_signed, div_mod, src1[32], src2[32], res_from_mem, mem_we, rf_we, rf_waddr[5], st_data[32]}
//  MEM_allowin       in   1    mem_stage can accept this cycle
//  EX_allowin        out  1    EX can accept from ID
//  MEM_signal_valid  out  1    EX holds a completed instruction
//  MEM_signal        out  71   {pc[32], res_from_mem, rf_we, rf_waddr[5], result[32]}
//  data_sram_en      out  1    SRAM request strobe
//  data_sram_we      out  4    byte write enables
//  data_sram_addr    out  32   = ALU sum
//  data_sram_wdata   out  32   = st_data
// BEHAVIOUR
//  Reset (async, resetn=0):
//   - EX_valid=0 and div state=IDLE; all latched fields cleared to 0.
//   - Outputs while in reset: EX_allowin=1, MEM_signal_valid=0, data_sram_en=0, data_sram_we=0.
//  Handshake:
//   - EX_readygo = !EX_valid | !div_en | (state==DONE).
//   - EX_allowin = !EX_valid | (EX_readygo & MEM_allowin).
//   - ID_signal_valid & EX_allowin: latch ID_signal, EX_valid<=1.
//   - Else if EX_readygo & MEM_allowin: EX_valid<=0.
//   - MEM_signal_valid = EX_valid & EX_readygo.
//   - Latched fields stay stable while stalled.
//  ALU (single cycle, result combinational from latched fields), alu_op one-hot:
//   - [0] add, [1] sub, [2] slt (signed), [3] sltu.
//   - [4] and, [5] nor, [6] or, [7] xor.
//   - [8] sll, [9] srl, [10] sra; shift amount = src2[4:0].
//   - [11] lui: result = src2.
//   - Add/sub wrap modulo 2^32; no overflow trap.
//   - All-zero alu_op yields 0.
//   - data_sram_addr is always the add result.
//  Divider FSM (used only when div_en=1; alu_op ignored):
//   - IDLE -> BUSY on the first cycle EX_valid & div_en & state==IDLE.
//     That cycle captures |src1|,|src2| (if div_signed), the sign flags, and counter=0.
//   - BUSY: one restoring shift-subtract step per cycle; counter++.
//     After step DIV_ITER-1, go to DONE and fix signs.
//   - Sign rules: quotient negated if signs differ; remainder takes the dividend sign.
//   - DONE: result = div_mod ? remainder : quotient.
//     DONE -> IDLE on the cycle the instruction leaves EX (EX_readygo & MEM_allowin).
//   - Latency: 1 setup + 32 BUSY = 33 cycles of EX_readygo=0, then DONE.
//   - Divide by zero (src2==0): quotient=0xFFFFFFFF, remainder=src1. No exception, same latency.
//   - Signed 0x80000000 / -1: quotient=0x80000000, remainder=0.
//   - A new div can only start after the previous one leaves EX, since EX_allowin=0 while stalled.
//  SRAM request:
//   - data_sram_en = EX_valid & EX_readygo & MEM_allowin & (res_from_mem | mem_we).
//   - data_sram_we = {4{data_sram_en & mem_we}}.
//   - Exactly one request per instruction, issued on its EX->MEM transfer cycle.
//   - res_from_mem & mem_we both set: treated as a store; the flag is forwarded unchanged.
//  Reset mid-division: FSM->IDLE and EX_valid->0 immediately. No SRAM request is issued.
// TESTING
//  T1 add:
//   - src1=0x7FFFFFFF, src2=1, alu_op[0], MEM_allowin=1.
//   - Next cycle MEM_signal result=0x80000000 and MEM_signal_valid=1.
//  T2 back-pressure:
//   - Hold MEM_allowin=0 for 3 cycles with EX full.
//   - EX_allowin=0, MEM_signal constant, data_sram_en=0 throughout.
//   - en pulses exactly once after release.
//  T3 signed div:
//   - src1=-7 (0xFFFFFFF9), src2=2, div_signed.
//   - Quotient 0xFFFFFFFD (-3) after 33 stall cycles; with div_mod, remainder 0xFFFFFFFF (-1).
//  T4 div-by-zero, unsigned:
//   - src1=0x1234, src2=0.
//   - Quotient 0xFFFFFFFF; with div_mod, remainder 0x1234.
//  T5 store:
//   - mem_we, src1=0x1000, src2=4, st_data=0xDEADBEEF.
//   - data_sram_en=1, we=4'hF, addr=0x1004, wdata=0xDEADBEEF, single cycle.
//  T6 reset:
//   - Assert resetn=0 at BUSY step 10.
//   - EX_valid=0 and FSM=IDLE asynchronously; next div after release takes the full 33 cycles.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: ID->EX pipeline register, single-cycle ALU, multi-cycle
// restoring divider, data-SRAM request and the MEM-stage bundle.
`timescale 1ns/1ps
module ex_stage #(
  parameter int XLEN     = 32,
  parameter int DIV_ITER = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 ID_signal_valid,
  input  logic [4*XLEN+22:0]   ID_signal,
  input  logic                 MEM_allowin,
  output logic                 EX_allowin,
  output logic                 MEM_signal_valid,
  output logic [2*XLEN+6:0]    MEM_signal,
  output logic                 data_sram_en,
  output logic [3:0]           data_sram_we,
  output logic [XLEN-1:0]      data_sram_addr,
  output logic [XLEN-1:0]      data_sram_wdata
);

  // Field offsets inside the ID bundle (LSB first).
  localparam int ID_W      = 4*XLEN + 23;
  localparam int WADDR_LSB = XLEN;
  localparam int RFWE_BIT  = XLEN + 5;
  localparam int MWE_BIT   = XLEN + 6;
  localparam int RFM_BIT   = XLEN + 7;
  localparam int SRC2_LSB  = XLEN + 8;
  localparam int SRC1_LSB  = 2*XLEN + 8;
  localparam int DMOD_BIT  = 3*XLEN + 8;
  localparam int DSGN_BIT  = 3*XLEN + 9;
  localparam int DEN_BIT   = 3*XLEN + 10;
  localparam int OP_LSB    = 3*XLEN + 11;
  localparam int PC_LSB    = 3*XLEN + 23;
  localparam int CNT_W     = $clog2(DIV_ITER) + 1;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_BUSY = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  // Pipeline register
  logic            ex_valid_reg, ex_valid_next;
  logic [ID_W-1:0] id_reg, id_next;

  // Latched fields
  logic [XLEN-1:0] ex_pc, ex_src1, ex_src2, ex_st_data;
  logic [11:0]     ex_alu_op;
  logic            ex_div_en, ex_div_signed, ex_div_mod;
  logic            ex_res_from_mem, ex_mem_we, ex_rf_we;
  logic [4:0]      ex_rf_waddr;

  assign ex_st_data      = id_reg[0 +: XLEN];
  assign ex_rf_waddr     = id_reg[WADDR_LSB +: 5];
  assign ex_rf_we        = id_reg[RFWE_BIT];
  assign ex_mem_we       = id_reg[MWE_BIT];
  assign ex_res_from_mem = id_reg[RFM_BIT];
  assign ex_src2         = id_reg[SRC2_LSB +: XLEN];
  assign ex_src1         = id_reg[SRC1_LSB +: XLEN];
  assign ex_div_mod      = id_reg[DMOD_BIT];
  assign ex_div_signed   = id_reg[DSGN_BIT];
  assign ex_div_en       = id_reg[DEN_BIT];
  assign ex_alu_op       = id_reg[OP_LSB +: 12];
  assign ex_pc           = id_reg[PC_LSB +: XLEN];

  // Divider state
  logic [1:0]      div_state_reg, div_state_next;
  logic [CNT_W-1:0] div_cnt_reg, div_cnt_next;
  logic [XLEN-1:0] div_rem_reg, div_rem_next;
  logic [XLEN-1:0] div_quo_reg, div_quo_next;
  logic [XLEN-1:0] div_dvs_reg, div_dvs_next;
  logic            quo_neg_reg, quo_neg_next;
  logic            rem_neg_reg, rem_neg_next;

  // Handshake
  logic ex_readygo, ex_leave;
  assign ex_readygo       = !ex_valid_reg || !ex_div_en || (div_state_reg == DIV_DONE);
  assign ex_leave         = ex_readygo && MEM_allowin;
  assign EX_allowin       = !ex_valid_reg || ex_leave;
  assign MEM_signal_valid = ex_valid_reg && ex_readygo;

  // ID->EX transfer: load on accept, drain on leave, otherwise hold
  always_comb begin
    ex_valid_next = ex_valid_reg;
    id_next       = id_reg;
    if (ID_signal_valid && EX_allowin) begin
      ex_valid_next = 1'b1;
      id_next       = ID_signal;
    end else if (ex_leave) begin
      ex_valid_next = 1'b0;
    end
  end

  // Pipeline register update
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ex_valid_reg <= 1'b0;
      id_reg       <= '0;
    end else begin
      ex_valid_reg <= ex_valid_next;
      id_reg       <= id_next;
    end
  end

  // ALU: one candidate result per one-hot opcode bit, masked and OR-ed
  logic [XLEN-1:0] sum;
  logic [4:0]      shamt;
  logic [XLEN-1:0] op_res  [12];
  logic [XLEN-1:0] op_mask [12];
  logic [XLEN-1:0] alu_result;

  assign sum   = ex_src1 + ex_src2;
  assign shamt = ex_src2[4:0];

  assign op_res[0]  = sum;
  assign op_res[1]  = ex_src1 - ex_src2;
  assign op_res[2]  = {{(XLEN-1){1'b0}}, ($signed(ex_src1) < $signed(ex_src2))};
  assign op_res[3]  = {{(XLEN-1){1'b0}}, (ex_src1 < ex_src2)};
  assign op_res[4]  = ex_src1 & ex_src2;
  assign op_res[5]  = ~(ex_src1 | ex_src2);
  assign op_res[6]  = ex_src1 | ex_src2;
  assign op_res[7]  = ex_src1 ^ ex_src2;
  assign op_res[8]  = ex_src1 << shamt;
  assign op_res[9]  = ex_src1 >> shamt;
  assign op_res[10] = XLEN'($signed(ex_src1) >>> shamt);
  assign op_res[11] = ex_src2;

  generate
    for (genvar gi = 0; gi < 12; gi++) begin : g_alu_mask
      assign op_mask[gi] = {XLEN{ex_alu_op[gi]}} & op_res[gi];
    end
  endgenerate

  // OR-reduce the masked candidates; all-zero opcode yields zero
  always_comb begin
    alu_result = '0;
    for (int i = 0; i < 12; i++) begin
      alu_result = alu_result | op_mask[i];
    end
  end

  // Divider datapath: magnitudes for setup and one restoring step
  logic            src1_neg, src2_neg;
  logic [XLEN-1:0] src1_abs, src2_abs;
  logic [XLEN:0]   rem_shift, rem_diff;
  logic            step_ok;
  logic [XLEN-1:0] step_rem, step_quo;

  assign src1_neg  = ex_div_signed && ex_src1[XLEN-1];
  assign src2_neg  = ex_div_signed && ex_src2[XLEN-1];
  assign src1_abs  = src1_neg ? (~ex_src1 + 1'b1) : ex_src1;
  assign src2_abs  = src2_neg ? (~ex_src2 + 1'b1) : ex_src2;
  assign rem_shift = {div_rem_reg, div_quo_reg[XLEN-1]};
  assign rem_diff  = rem_shift - {1'b0, div_dvs_reg};
  assign step_ok   = !rem_diff[XLEN];
  assign step_rem  = step_ok ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
  assign step_quo  = {div_quo_reg[XLEN-2:0], step_ok};

  // Divider FSM: setup cycle, DIV_ITER steps, then hold result until leave
  always_comb begin
    div_state_next = div_state_reg;
    div_cnt_next   = div_cnt_reg;
    div_rem_next   = div_rem_reg;
    div_quo_next   = div_quo_reg;
    div_dvs_next   = div_dvs_reg;
    quo_neg_next   = quo_neg_reg;
    rem_neg_next   = rem_neg_reg;
    case (div_state_reg)
      DIV_IDLE: begin
        if (ex_valid_reg && ex_div_en) begin
          div_state_next = DIV_BUSY;
          div_cnt_next   = '0;
          div_rem_next   = '0;
          div_quo_next   = src1_abs;
          div_dvs_next   = src2_abs;
          // A zero divisor keeps the all-ones quotient unsigned-looking.
          quo_neg_next   = (src1_neg ^ src2_neg) && (ex_src2 != '0);
          rem_neg_next   = src1_neg;
        end
      end
      DIV_BUSY: begin
        div_cnt_next = div_cnt_reg + 1'b1;
        div_rem_next = step_rem;
        div_quo_next = step_quo;
        if (div_cnt_reg == CNT_W'(DIV_ITER-1)) begin
          div_state_next = DIV_DONE;
          div_rem_next   = rem_neg_reg ? (~step_rem + 1'b1) : step_rem;
          div_quo_next   = quo_neg_reg ? (~step_quo + 1'b1) : step_quo;
        end
      end
      DIV_DONE: begin
        if (ex_leave) begin
          div_state_next = DIV_IDLE;
        end
      end
      default: div_state_next = DIV_IDLE;
    endcase
  end

  // Divider register update
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_state_reg <= DIV_IDLE;
      div_cnt_reg   <= '0;
      div_rem_reg   <= '0;
      div_quo_reg   <= '0;
      div_dvs_reg   <= '0;
      quo_neg_reg   <= 1'b0;
      rem_neg_reg   <= 1'b0;
    end else begin
      div_state_reg <= div_state_next;
      div_cnt_reg   <= div_cnt_next;
      div_rem_reg   <= div_rem_next;
      div_quo_reg   <= div_quo_next;
      div_dvs_reg   <= div_dvs_next;
      quo_neg_reg   <= quo_neg_next;
      rem_neg_reg   <= rem_neg_next;
    end
  end

  // Result selection and MEM bundle
  logic [XLEN-1:0] ex_result;
  assign ex_result  = ex_div_en ? (ex_div_mod ? div_rem_reg : div_quo_reg) : alu_result;
  assign MEM_signal = {ex_pc, ex_res_from_mem, ex_rf_we, ex_rf_waddr, ex_result};

  // SRAM request fires once, on the EX->MEM transfer cycle
  assign data_sram_en    = ex_valid_reg && ex_leave && (ex_res_from_mem || ex_mem_we);
  assign data_sram_we    = {4{data_sram_en && ex_mem_we}};
  assign data_sram_addr  = sum;
  assign data_sram_wdata = ex_st_data;

endmodule
